// File: rtl/mmu_arb_pkg.sv
// Shared encodings and the request bundle for the MMU data-port arbiter.
package mmu_arb_pkg;

    // Which requester owns the read response coming back next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // 70-bit request bundle presented to the MMU data port.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic        sgn;
    } req_t;

endpackage

// File: rtl/mmu_dport_req_mux.sv
// Selects the granted requester's bundle onto the MMU port. With no grant
// the bundle is all zero, so be/we are 0 and no write or IO access occurs.
module mmu_dport_req_mux
    import mmu_arb_pkg::*;
(
    input  logic c_sel,
    input  logic d_sel,
    input  req_t c_bus,
    input  req_t d_bus,
    output req_t m_bus
);

    // Grants are mutually exclusive; debug checked first only for clarity.
    always_comb begin
        m_bus = '0;
        if (d_sel)
            m_bus = d_bus;
        else if (c_sel)
            m_bus = c_bus;
    end

endmodule

// File: rtl/mmu_dport_arbiter.sv
// Arbitrates the MMU data port between the CPU load/store stage and the
// debug/loader master. CPU wins by default, a starvation counter forces a
// debug slot, and a lock mode hands the port to debug for bursts.
module mmu_dport_arbiter
    import mmu_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic        clk,
    input  logic        resetb,

    input  logic        c_req,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [3:0]  c_be,
    input  logic        c_we,
    input  logic        c_signed,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,

    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    input  logic        d_we,
    input  logic        d_signed,
    input  logic        d_lock,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic [31:0] m_addr,
    output logic [31:0] m_di,
    output logic [3:0]  m_be,
    output logic        m_we,
    output logic        m_signed,
    input  logic [31:0] m_do,

    output logic        locked
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    state_t           state, state_nx;
    logic [CNT_W-1:0] starve_cnt;
    owner_t           owner_p;
    req_t             c_bus, d_bus, m_bus;

    // Grant selection and next state; grants are held off during reset.
    always_comb begin
        c_gnt    = 1'b0;
        d_gnt    = 1'b0;
        state_nx = state;
        if (resetb) begin
            case (state)
                ST_NORMAL: begin
                    if (d_req && starve_cnt == CNT_MAX)
                        d_gnt = 1'b1;
                    else if (c_req)
                        c_gnt = 1'b1;
                    else if (d_req)
                        d_gnt = 1'b1;
                    if (d_gnt && d_lock)
                        state_nx = ST_LOCKED;
                end
                ST_LOCKED: begin
                    d_gnt = d_req;
                    if (!d_lock)
                        state_nx = ST_NORMAL;
                end
                default: state_nx = ST_NORMAL;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)
            state <= ST_NORMAL;
        else
            state <= state_nx;
    end

    // Starvation counter: counts consecutive denied debug cycles, saturating.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)
            starve_cnt <= '0;
        else if (state == ST_NORMAL && state_nx == ST_LOCKED)
            starve_cnt <= '0;
        else if (d_req && !d_gnt)
            starve_cnt <= (starve_cnt == CNT_MAX) ? CNT_MAX : starve_cnt + 1'b1;
        else
            starve_cnt <= '0;
    end

    // Remember who owns the read data the MMU returns next cycle.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)
            owner_p <= OWN_NONE;
        else if (c_gnt && !c_we)
            owner_p <= OWN_CPU;
        else if (d_gnt && !d_we)
            owner_p <= OWN_DBG;
        else
            owner_p <= OWN_NONE;
    end

    assign c_rvalid = (owner_p == OWN_CPU);
    assign d_rvalid = (owner_p == OWN_DBG);
    assign c_rdata  = c_rvalid ? m_do : 32'h0;
    assign d_rdata  = d_rvalid ? m_do : 32'h0;
    assign locked   = (state == ST_LOCKED);

    assign c_bus = '{addr: c_addr, wdata: c_wdata, be: c_be, we: c_we, sgn: c_signed};
    assign d_bus = '{addr: d_addr, wdata: d_wdata, be: d_be, we: d_we, sgn: d_signed};

    mmu_dport_req_mux u_req_mux (
        .c_sel (c_gnt),
        .d_sel (d_gnt),
        .c_bus (c_bus),
        .d_bus (d_bus),
        .m_bus (m_bus)
    );

    assign m_addr   = m_bus.addr;
    assign m_di     = m_bus.wdata;
    assign m_be     = m_bus.be;
    assign m_we     = m_bus.we;
    assign m_signed = m_bus.sgn;

endmodule

// File: tb/tb_mmu_dport_arbiter.sv
// Directed plus randomized bench for mmu_dport_arbiter against a small
// behavioural model of the arbitration, lock and response rules.
module tb_mmu_dport_arbiter;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        resetb;
    logic        c_req, c_we, c_signed, d_req, d_we, d_signed, d_lock;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata, m_do;
    logic [3:0]  c_be, d_be;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid, m_we, m_signed, locked;
    logic [31:0] c_rdata, d_rdata, m_addr, m_di;
    logic [3:0]  m_be;

    mmu_dport_arbiter #(.STARVE_MAX(SMAX), .CNT_W(3)) dut (
        .clk(clk), .resetb(resetb),
        .c_req(c_req), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
        .c_we(c_we), .c_signed(c_signed), .c_gnt(c_gnt),
        .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_we(d_we), .d_signed(d_signed), .d_lock(d_lock), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_addr(m_addr), .m_di(m_di), .m_be(m_be), .m_we(m_we),
        .m_signed(m_signed), .m_do(m_do), .locked(locked)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: lock flag, denied-cycle count, pending reader
    // (0 none, 1 cpu, 2 debug), and this cycle's expected grants.
    bit mdl_lock;
    int mdl_starve;
    int mdl_pend;
    bit e_cg, e_dg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        c_req = 0; c_we = 0; c_signed = 0; c_addr = 0; c_wdata = 0; c_be = 0;
        d_req = 0; d_we = 0; d_signed = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        d_lock = 0;
    endtask

    // Let inputs settle, then compare every output against the model.
    task automatic check_cycle();
        logic [31:0] xa, xd;
        logic [3:0]  xb;
        logic        xw, xs;
        #2;
        if (!resetb) begin
            mdl_lock = 0; mdl_starve = 0; mdl_pend = 0;
        end
        e_cg = 0; e_dg = 0;
        if (resetb) begin
            if (mdl_lock)                      e_dg = d_req;
            else if (d_req && mdl_starve == SMAX) e_dg = 1;
            else if (c_req)                    e_cg = 1;
            else if (d_req)                    e_dg = 1;
        end
        xa = 0; xd = 0; xb = 0; xw = 0; xs = 0;
        if (e_cg) begin xa = c_addr; xd = c_wdata; xb = c_be; xw = c_we; xs = c_signed; end
        if (e_dg) begin xa = d_addr; xd = d_wdata; xb = d_be; xw = d_we; xs = d_signed; end
        chk("c_gnt", c_gnt, e_cg);
        chk("d_gnt", d_gnt, e_dg);
        chk("m_addr", m_addr, xa);
        chk("m_di", m_di, xd);
        chk("m_be", m_be, xb);
        chk("m_we", m_we, xw);
        chk("m_signed", m_signed, xs);
        chk("c_rvalid", c_rvalid, mdl_pend == 1);
        chk("d_rvalid", d_rvalid, mdl_pend == 2);
        chk("c_rdata", c_rdata, (mdl_pend == 1) ? m_do : 32'h0);
        chk("d_rdata", d_rdata, (mdl_pend == 2) ? m_do : 32'h0);
        chk("locked", locked, mdl_lock);
    endtask

    // Advance one clock, updating the model from this cycle's inputs.
    task automatic tick();
        @(posedge clk);
        if (!resetb) begin
            mdl_lock = 0; mdl_starve = 0; mdl_pend = 0;
        end else begin
            mdl_pend = (e_cg && !c_we) ? 1 : (e_dg && !d_we) ? 2 : 0;
            if (!mdl_lock && e_dg && d_lock) begin
                mdl_lock = 1;
                mdl_starve = 0;
            end else begin
                if (d_req && !e_dg) mdl_starve = (mdl_starve < SMAX) ? mdl_starve + 1 : SMAX;
                else                mdl_starve = 0;
                if (mdl_lock && !d_lock) mdl_lock = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic step();
        check_cycle();
        tick();
    endtask

    initial begin
        idle();
        m_do = 0;
        resetb = 0;
        mdl_lock = 0; mdl_starve = 0; mdl_pend = 0;
        @(negedge clk);
        step();
        resetb = 1;
        step();

        // Reset asserted while a CPU read response is pending.
        c_req = 1; c_addr = 32'h100; c_be = 4'hF;
        step();
        resetb = 0;
        m_do = 32'hCAFEF00D;
        check_cycle();
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_c_gnt", c_gnt, 0);
        chk("rst_locked", locked, 0);
        chk("rst_m_we_be", {m_we, m_be}, 0);
        tick();
        resetb = 1;
        idle();
        step();

        // CPU read with 1-cycle response.
        c_req = 1; c_addr = 32'h10000010; c_be = 4'b1111;
        check_cycle();
        chk("cpu_rd_gnt", c_gnt, 1);
        chk("cpu_rd_addr", m_addr, 32'h10000010);
        tick();
        idle(); m_do = 32'hDEADBEEF;
        check_cycle();
        chk("cpu_rd_rvalid", c_rvalid, 1);
        chk("cpu_rd_rdata", c_rdata, 32'hDEADBEEF);
        chk("cpu_rd_d_rvalid", d_rvalid, 0);
        tick();
        step();

        // Starvation: both request for 6 cycles.
        c_req = 1; c_addr = 32'h20; c_be = 4'hF;
        d_req = 1; d_addr = 32'h30; d_be = 4'hF;
        for (int i = 0; i < 6; i++) begin
            check_cycle();
            chk("starve_c_gnt", c_gnt, i != 4);
            chk("starve_d_gnt", d_gnt, i == 4);
            tick();
        end
        idle();
        step();

        // Lock burst against a competing CPU.
        c_req = 1; c_addr = 32'h40; c_be = 4'hF;
        d_req = 1; d_addr = 32'h50; d_be = 4'hF; d_lock = 1;
        for (int i = 0; i < 9; i++) begin
            check_cycle();
            if (i >= 5) begin
                chk("lock_status", locked, 1);
                chk("lock_d_gnt", d_gnt, 1);
                chk("lock_c_gnt", c_gnt, 0);
            end
            tick();
        end
        d_lock = 0;
        step();
        check_cycle();
        chk("unlock_status", locked, 0);
        chk("unlock_c_gnt", c_gnt, 1);
        tick();
        idle();
        step();

        // Interleaved reads to alternating owners.
        c_req = 1; c_addr = 32'h60; c_be = 4'hF;
        step();
        idle(); d_req = 1; d_addr = 32'h70; d_be = 4'hF; m_do = 32'h11111111;
        check_cycle();
        chk("il_c_rdata", c_rdata, 32'h11111111);
        chk("il_d_rvalid0", d_rvalid, 0);
        tick();
        idle(); m_do = 32'h22222222;
        check_cycle();
        chk("il_d_rdata", d_rdata, 32'h22222222);
        chk("il_c_rvalid1", c_rvalid, 0);
        tick();

        // Debug write then idle.
        d_req = 1; d_we = 1; d_addr = 32'h80000004; d_wdata = 32'h5A; d_be = 4'b0001;
        check_cycle();
        chk("wr_m_we", m_we, 1);
        chk("wr_m_di", m_di, 32'h5A);
        tick();
        idle();
        check_cycle();
        chk("wr_no_rvalid", {c_rvalid, d_rvalid}, 0);
        chk("idle_m_be", m_be, 0);
        tick();

        // Randomized traffic, occasional lock bursts and resets.
        for (int i = 0; i < 400; i++) begin
            c_req = $urandom_range(0, 1); c_addr = $urandom; c_wdata = $urandom;
            c_be = 4'($urandom); c_we = $urandom_range(0, 1); c_signed = $urandom_range(0, 1);
            d_req = $urandom_range(0, 2) != 0; d_addr = $urandom; d_wdata = $urandom;
            d_be = 4'($urandom); d_we = $urandom_range(0, 1); d_signed = $urandom_range(0, 1);
            if ($urandom_range(0, 5) == 0) d_lock = ~d_lock;
            m_do = $urandom;
            resetb = $urandom_range(0, 60) != 0;
            step();
        end
        resetb = 1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
